// File: rtl/wb_burst_master.sv
// Wishbone burst initiator: one 128-bit line as a 4-beat incrementing burst
// plus an end-of-burst terminator cycle, with bus-error and timeout abort.
module wb_burst_master #(
  parameter int TIMEOUT = 255
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req,
  input  logic             i_we,
  input  logic [31:0]      i_addr,
  input  logic [3:0][31:0] i_line_data,
  input  logic [3:0][3:0]  i_line_strb,
  output logic [3:0][31:0] o_line_data,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic             o_wb_cyc,
  output logic             o_wb_stb,
  output logic             o_wb_we,
  output logic [2:0]       o_wb_cti,
  output logic [3:0]       o_wb_sel,
  output logic [31:0]      o_wb_addr,
  output logic [31:0]      o_wb_data,
  input  logic             i_wb_ack,
  input  logic             i_wb_err,
  input  logic [31:0]      i_wb_data
);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BURST, TERM, DONE} state_t;

  state_t           state, state_n;
  logic [1:0]       beat, beat_n;
  logic [TW-1:0]    tcnt, tcnt_n;
  logic             we_q, we_n;
  logic [27:0]      line_q, line_n;
  logic [3:0][31:0] wdata_q, wdata_n;
  logic [3:0][3:0]  strb_q, strb_n;
  logic             accept, capture, abort;
  logic             bus_on;

  always_comb begin
    state_n = state;
    beat_n  = beat;
    tcnt_n  = tcnt;
    we_n    = we_q;
    line_n  = line_q;
    wdata_n = wdata_q;
    strb_n  = strb_q;
    accept  = 1'b0;
    capture = 1'b0;
    abort   = 1'b0;
    case (state)
      IDLE: if (i_req) begin
        accept  = 1'b1;
        state_n = BURST;
        beat_n  = '0;
        tcnt_n  = '0;
        we_n    = i_we;
        line_n  = i_addr[31:4];
        wdata_n = i_line_data;
        strb_n  = i_line_strb;
      end
      BURST: begin
        // err beats ack, ack beats timeout
        if (i_wb_err) begin
          abort   = 1'b1;
          state_n = DONE;
        end else if (i_wb_ack) begin
          capture = !we_q;
          tcnt_n  = '0;
          beat_n  = beat + 2'd1;
          if (beat == 2'd3) state_n = TERM;
        end else begin
          if (tcnt != TW'(TIMEOUT)) tcnt_n = tcnt + TW'(1);
          if (tcnt_n == TW'(TIMEOUT)) begin
            abort   = 1'b1;
            state_n = DONE;
          end
        end
      end
      TERM:    state_n = DONE;
      default: state_n = IDLE;
    endcase
  end

  assign bus_on = (state_n == BURST) || (state_n == TERM);

  // Bus outputs are registered from next-state values so beat 0 appears the
  // cycle right after acceptance and each beat advances on its ack edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      beat        <= '0;
      tcnt        <= '0;
      we_q        <= 1'b0;
      line_q      <= '0;
      wdata_q     <= '0;
      strb_q      <= '0;
      o_line_data <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_err       <= 1'b0;
      o_wb_cyc    <= 1'b0;
      o_wb_stb    <= 1'b0;
      o_wb_we     <= 1'b0;
      o_wb_cti    <= 3'b000;
      o_wb_sel    <= 4'h0;
      o_wb_addr   <= '0;
      o_wb_data   <= '0;
    end else begin
      state   <= state_n;
      beat    <= beat_n;
      tcnt    <= tcnt_n;
      we_q    <= we_n;
      line_q  <= line_n;
      wdata_q <= wdata_n;
      strb_q  <= strb_n;
      if (capture) o_line_data[beat] <= i_wb_data;
      o_busy <= (state_n != IDLE);
      o_done <= (state_n == DONE);
      if (accept)     o_err <= 1'b0;
      else if (abort) o_err <= 1'b1;
      o_wb_cyc <= bus_on;
      o_wb_stb <= bus_on;
      o_wb_we  <= bus_on & we_n;
      if (state_n == BURST) begin
        o_wb_cti  <= 3'b010;
        o_wb_addr <= {line_n, beat_n, 2'b00};
        o_wb_sel  <= we_n ? strb_n[beat_n] : 4'hF;
        o_wb_data <= we_n ? wdata_n[beat_n] : 32'h0;
      end else if (state_n == TERM) begin
        o_wb_cti  <= 3'b111;
        o_wb_addr <= {line_n, 2'b11, 2'b00};
        o_wb_sel  <= 4'h0;
        o_wb_data <= 32'h0;
      end else begin
        o_wb_cti  <= 3'b000;
        o_wb_addr <= 32'h0;
        o_wb_sel  <= 4'h0;
        o_wb_data <= 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_wb_burst_master.sv
// Self-checking bench for wb_burst_master: transaction-level model compared
// every cycle, plus literal checks on latencies and returned lines.
module tb_wb_burst_master;
  localparam int TO = 4;
  localparam int P_IDLE = 0, P_BURST = 1, P_TERM = 2, P_DONE = 3;

  logic             i_clk = 1'b0;
  logic             i_rst = 1'b1;
  logic             i_req = 1'b0;
  logic             i_we = 1'b0;
  logic [31:0]      i_addr = '0;
  logic [3:0][31:0] i_line_data = '0;
  logic [3:0][3:0]  i_line_strb = '0;
  logic [3:0][31:0] o_line_data;
  logic             o_busy, o_done, o_err;
  logic             o_wb_cyc, o_wb_stb, o_wb_we;
  logic [2:0]       o_wb_cti;
  logic [3:0]       o_wb_sel;
  logic [31:0]      o_wb_addr, o_wb_data;
  logic             i_wb_ack = 1'b0;
  logic             i_wb_err = 1'b0;
  logic [31:0]      i_wb_data = '0;

  int checks = 0;
  int fails  = 0;

  wb_burst_master #(.TIMEOUT(TO)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_we(i_we), .i_addr(i_addr),
    .i_line_data(i_line_data), .i_line_strb(i_line_strb), .o_line_data(o_line_data),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we), .o_wb_cti(o_wb_cti),
    .o_wb_sel(o_wb_sel), .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data),
    .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err), .i_wb_data(i_wb_data)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Line-level model: phase, acks taken, silent cycles since last ack.
  int               ph;
  logic [2:0]       acks;
  int               silent;
  logic             m_we, m_err;
  logic [27:0]      m_line;
  logic [3:0][31:0] m_wd, m_rd;
  logic [3:0][3:0]  m_st;

  always @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ph <= P_IDLE; acks <= '0; silent <= 0; m_we <= 1'b0; m_err <= 1'b0;
      m_line <= '0; m_wd <= '0; m_rd <= '0; m_st <= '0;
    end else begin
      case (ph)
        P_IDLE: if (i_req) begin
          ph <= P_BURST; acks <= '0; silent <= 0; m_we <= i_we; m_err <= 1'b0;
          m_line <= i_addr[31:4]; m_wd <= i_line_data; m_st <= i_line_strb;
        end
        P_BURST:
          if (i_wb_err) begin
            ph <= P_DONE; m_err <= 1'b1;
          end else if (i_wb_ack) begin
            if (!m_we) m_rd[acks[1:0]] <= i_wb_data;
            acks <= acks + 3'd1; silent <= 0;
            if (acks == 3'd3) ph <= P_TERM;
          end else begin
            silent <= silent + 1;
            if (silent + 1 == TO) begin ph <= P_DONE; m_err <= 1'b1; end
          end
        P_TERM:  ph <= P_DONE;
        default: ph <= P_IDLE;
      endcase
    end
  end

  logic        e_cyc, e_we;
  logic [2:0]  e_cti;
  logic [31:0] e_addr, e_dat;
  logic [3:0]  e_sel;
  always_comb begin
    e_cyc  = (ph == P_BURST) || (ph == P_TERM);
    e_we   = e_cyc && m_we;
    e_cti  = (ph == P_BURST) ? 3'b010 : (ph == P_TERM) ? 3'b111 : 3'b000;
    e_addr = (ph == P_BURST) ? {m_line, acks[1:0], 2'b00} :
             (ph == P_TERM)  ? {m_line, 4'hC} : 32'h0;
    e_sel  = (ph == P_BURST) ? (m_we ? m_st[acks[1:0]] : 4'hF) : 4'h0;
    e_dat  = (ph == P_BURST && m_we) ? m_wd[acks[1:0]] : 32'h0;
  end

  always @(negedge i_clk) begin
    chk("cyc",  o_wb_cyc, e_cyc);
    chk("stb",  o_wb_stb, e_cyc);
    chk("we",   o_wb_we, e_we);
    chk("cti",  o_wb_cti, e_cti);
    chk("addr", o_wb_addr, e_addr);
    chk("sel",  o_wb_sel, e_sel);
    chk("wdat", o_wb_data, e_dat);
    chk("busy", o_busy, ph != P_IDLE);
    chk("done", o_done, ph == P_DONE);
    chk("err",  o_err, m_err);
    chk("line", o_line_data, m_rd);
  end

  task automatic tick();
    @(posedge i_clk); #1;
  endtask

  task automatic start(input logic we, input logic [31:0] addr,
                       input logic [127:0] wd, input logic [15:0] st);
    i_we = we; i_addr = addr; i_line_data = wd; i_line_strb = st; i_req = 1'b1;
    tick();
    i_req = 1'b0;
  endtask

  // Responder: ack each beat after dly wait cycles, raise ack+err on err_beat,
  // never answer stall_beat, and ack the terminator (which must be ignored).
  task automatic serve(input int dly, input int err_beat, input int stall_beat,
                       input logic poke, input logic [31:0] base,
                       output int ncyc, output int nterm, output logic [31:0] taddr);
    int wc;
    wc = 0; ncyc = 0; nterm = 0; taddr = '0;
    while (!o_done && ncyc < 200) begin
      i_wb_ack = 1'b0; i_wb_err = 1'b0; i_req = poke;
      i_wb_data = base + {30'd0, o_wb_addr[3:2]};
      if (o_wb_cyc && o_wb_cti == 3'b010) begin
        if (wc >= dly && int'(o_wb_addr[3:2]) != stall_beat) begin
          i_wb_ack = 1'b1;
          if (int'(o_wb_addr[3:2]) == err_beat) i_wb_err = 1'b1;
        end
      end else if (o_wb_cyc) begin
        nterm++; taddr = o_wb_addr; i_wb_ack = 1'b1;
      end
      tick();
      ncyc++;
      if (i_wb_ack || i_wb_err) wc = 0; else wc++;
    end
    chk("serve_bound", ncyc < 200, 1'b1);
    i_wb_ack = 1'b0; i_wb_err = 1'b0; i_req = 1'b0;
  endtask

  initial begin
    int n, nt;
    logic [31:0] ta;
    repeat (2) tick();
    chk("rst_cyc", {o_wb_cyc, o_wb_stb, o_wb_we}, 3'b000);
    chk("rst_busy", {o_busy, o_done, o_err}, 3'b000);
    chk("rst_line", o_line_data, 128'h0);
    i_rst = 1'b0;
    i_wb_ack = 1'b1; i_wb_err = 1'b1; tick();
    i_wb_ack = 1'b0; i_wb_err = 1'b0; tick();
    chk("idle_stray", {o_busy, o_err, o_wb_cyc}, 3'b000);

    // read, ack every cycle
    start(1'b0, 32'h0000_123A, '0, '0);
    chk("rd_b0_addr", o_wb_addr, 32'h0000_1230);
    chk("rd_b0_cti", o_wb_cti, 3'b010);
    serve(0, 9, 9, 1'b0, 32'hA0, n, nt, ta);
    chk("rd_latency", n + 1, 6);
    chk("rd_term_cnt", nt, 1);
    chk("rd_term_addr", ta, 32'h0000_123C);
    chk("rd_line_lit", o_line_data, 128'h000000A3_000000A2_000000A1_000000A0);
    chk("rd_err", o_err, 1'b0);
    tick();

    // write, strobes F,3,0,C, ack after 2 wait cycles
    start(1'b1, 32'h0000_2000, {32'hDDDD0003, 32'hDDDD0002, 32'hDDDD0001, 32'hDDDD0000}, 16'hC03F);
    chk("wr_b0", {o_wb_we, o_wb_sel, o_wb_data}, {1'b1, 4'hF, 32'hDDDD0000});
    serve(2, 9, 9, 1'b0, 32'h55, n, nt, ta);
    chk("wr_latency", n + 1, 14);
    chk("wr_term_cnt", nt, 1);
    chk("wr_err", o_err, 1'b0);
    tick();

    // ack+err together on beat 2
    start(1'b0, 32'h0000_3000, '0, '0);
    serve(0, 2, 9, 1'b0, 32'hB0, n, nt, ta);
    chk("er_latency", n + 1, 4);
    chk("er_term_cnt", nt, 0);
    chk("er_cyc", o_wb_cyc, 1'b0);
    chk("er_flags", {o_done, o_err}, 2'b11);
    chk("er_line_lit", o_line_data, 128'h000000A3_000000A2_000000B1_000000B0);
    tick();

    // timeout on beat 2 with requests poked throughout busy
    start(1'b0, 32'h0000_4000, '0, '0);
    serve(0, 9, 2, 1'b1, 32'hC0, n, nt, ta);
    chk("to_latency", n + 1, 7);
    chk("to_term_cnt", nt, 0);
    chk("to_flags", {o_done, o_err}, 2'b11);
    chk("to_line_lit", o_line_data, 128'h000000A3_000000A2_000000C1_000000C0);
    i_req = 1'b1; i_addr = 32'h0000_9990;
    tick();
    i_req = 1'b0;
    chk("to_idle", {o_busy, o_err}, 2'b01);

    // request in first idle cycle; ack on the last timeout-free cycle
    start(1'b0, 32'h0000_5000, '0, '0);
    chk("nx_err_clr", {o_busy, o_err}, 2'b10);
    chk("nx_addr", o_wb_addr, 32'h0000_5000);
    serve(3, 9, 9, 1'b0, 32'hE0, n, nt, ta);
    chk("nx_latency", n + 1, 18);
    chk("nx_err", o_err, 1'b0);
    chk("nx_line_lit", o_line_data, 128'h000000E3_000000E2_000000E1_000000E0);
    tick();

    // async reset during beat 1
    start(1'b0, 32'h0000_6000, '0, '0);
    i_wb_ack = 1'b1; i_wb_data = 32'hF0;
    tick();
    i_wb_ack = 1'b0;
    #2 i_rst = 1'b1;
    #1;
    chk("ar_bus", {o_wb_cyc, o_wb_stb, o_wb_we, o_wb_cti, o_wb_sel}, 10'h0);
    chk("ar_addr", {o_wb_addr, o_wb_data}, 64'h0);
    chk("ar_stat", {o_busy, o_done, o_err}, 3'b000);
    chk("ar_line", o_line_data, 128'h0);
    tick();
    i_rst = 1'b0;
    tick();
    start(1'b0, 32'h0000_7000, '0, '0);
    serve(0, 9, 9, 1'b0, 32'h10, n, nt, ta);
    chk("pr_latency", n + 1, 6);
    chk("pr_line_lit", o_line_data, 128'h00000013_00000012_00000011_00000010);
    chk("pr_err", o_err, 1'b0);
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
